// File: rtl/exec_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU/MUL commands,
// shift types, FSM states and NZCV bit positions.
package exec_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic [3:0] dest;
  } ctrl_t;

endpackage

// File: rtl/iter_multiplier.sv
// Iterative multiply-accumulate retiring MUL_BPC multiplier bits per cycle;
// product = acc + a*b modulo 2^DATA_W, valid the cycle after done.
module iter_multiplier #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int STEPS = DATA_W / MUL_BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;

  // done marks the final step; the product register updates on that same edge
  assign done    = (cnt_q == CNT_W'(1));
  assign product = prod_q;

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d    = CNT_W'(STEPS);
      mcand_d  = a;
      mplier_d = b;
      prod_d   = acc;
    end else if (cnt_q != '0) begin
      prod_d   = prod_q + mcand_q * DATA_W'(mplier_q[MUL_BPC-1:0]);
      mcand_d  = mcand_q << MUL_BPC;
      mplier_d = mplier_q >> MUL_BPC;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/exec_stage_mc.sv
// Multi-cycle execute stage: forwarding, barrel shifter, ALU, branch target,
// iterative MUL/MLA and a valid/ready output register.
//   state | meaning
//   IDLE  | accepting ops; non-MUL results load the output register directly
//   MUL   | multiplier iterating, front end stalled
//   DONE  | product ready, waiting for the output register to free up
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 2,
  parameter int MUL_BPC  = 2,
  parameter int SEL_W    = $clog2(FWD_SRCS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic [3:0]                 exe_cmd,
  input  logic                       mem_r_en,
  input  logic                       mem_w_en,
  input  logic                       wb_en,
  input  logic [3:0]                 dest,
  input  logic [DATA_W-1:0]          val_rn,
  input  logic [DATA_W-1:0]          val_rm,
  input  logic [DATA_W-1:0]          val_ra,
  input  logic                       imm,
  input  logic [11:0]                shift_operand,
  input  logic [23:0]                signed_imm_24,
  input  logic [3:0]                 sr,
  input  logic [SEL_W-1:0]           src1_sel,
  input  logic [SEL_W-1:0]           src2_sel,
  input  logic [SEL_W-1:0]           src3_sel,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_values,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          alu_result,
  output logic [DATA_W-1:0]          br_addr,
  output logic [DATA_W-1:0]          out_store_data,
  output logic [3:0]                 status,
  output logic                       out_mem_r_en,
  output logic                       out_mem_w_en,
  output logic                       out_wb_en,
  output logic [3:0]                 out_dest,
  output logic                       busy
);

  localparam int WW = DATA_W + 1;

  function automatic logic [DATA_W-1:0] pick(input logic [SEL_W-1:0] sel,
                                             input logic [DATA_W-1:0] reg_val,
                                             input logic [FWD_SRCS*DATA_W-1:0] fwd);
    logic [DATA_W-1:0] v;
    v = reg_val;
    for (int k = 1; k <= FWD_SRCS; k++)
      if (int'(sel) == k) v = fwd[(k-1)*DATA_W +: DATA_W];
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] ror_fn(input logic [DATA_W-1:0] v, input int amt);
    return (v >> amt) | (v << (DATA_W - amt));
  endfunction

  function automatic logic [DATA_W-1:0] val2_fn(input logic is_imm, input logic is_mem,
                                                input logic [11:0] so,
                                                input logic [DATA_W-1:0] m);
    logic [DATA_W-1:0] v;
    int amt;
    amt = int'(so[11:7]);
    if (is_imm) v = ror_fn({{(DATA_W-8){1'b0}}, so[7:0]}, 2 * int'(so[11:8]));
    else if (is_mem) v = {{(DATA_W-12){1'b0}}, so};
    else begin
      case (so[6:5])
        SH_LSL:  v = m << amt;
        SH_LSR:  v = m >> amt;
        SH_ASR:  v = $signed(m) >>> amt;
        SH_ROR:  v = ror_fn(m, amt);
        default: v = m;
      endcase
    end
    return v;
  endfunction

  // returns {NZCV, result}; unknown codes give 0 and pass sr through
  function automatic logic [DATA_W+3:0] alu_fn(input logic [3:0] cmd,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [3:0] f_in);
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] r;
    logic [3:0]        f;
    logic              arith, add, logic_op;
    wide     = '0;
    r        = '0;
    f        = f_in;
    add      = (cmd == CMD_ADD) || (cmd == CMD_ADC);
    arith    = add || (cmd == CMD_SUB) || (cmd == CMD_SBC);
    logic_op = 1'b1;
    case (cmd)
      CMD_MOV: r = b;
      CMD_MVN: r = ~b;
      CMD_AND: r = a & b;
      CMD_ORR: r = a | b;
      CMD_EOR: r = a ^ b;
      CMD_ADD: wide = {1'b0, a} + {1'b0, b};
      CMD_ADC: wide = {1'b0, a} + {1'b0, b} + WW'(f_in[FLAG_C]);
      CMD_SUB: wide = {1'b0, a} - {1'b0, b};
      CMD_SBC: wide = {1'b0, a} - {1'b0, b} - WW'(!f_in[FLAG_C]);
      default: logic_op = 1'b0;
    endcase
    if (arith) begin
      r         = wide[DATA_W-1:0];
      f[FLAG_C] = add ? wide[DATA_W] : !wide[DATA_W];
      f[FLAG_V] = add ? (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1])
                      : (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end
    if (logic_op) begin
      f[FLAG_N] = r[DATA_W-1];
      f[FLAG_Z] = (r == '0);
    end
    return {f, r};
  endfunction

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d, br_q, br_d, store_q, store_d;
  logic [3:0]        status_q, status_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] p_br_q, p_br_d, p_store_q, p_store_d;
  logic [3:0]        p_sr_q, p_sr_d;
  ctrl_t             p_ctrl_q, p_ctrl_d;

  logic [DATA_W-1:0] op_a, op_m, op_c, val2, br_in, mul_acc, mul_prod;
  logic [DATA_W+3:0] alu_out;
  logic              is_mul, accept, mul_start, mul_done;
  ctrl_t             ctrl_in;

  assign op_a      = pick(src1_sel, val_rn, fwd_values);
  assign op_m      = pick(src2_sel, val_rm, fwd_values);
  assign op_c      = pick(src3_sel, val_ra, fwd_values);
  assign val2      = val2_fn(imm, mem_r_en || mem_w_en, shift_operand, op_m);
  assign alu_out   = alu_fn(exe_cmd, op_a, val2, sr);
  assign br_in     = pc_in + {{(DATA_W-24){signed_imm_24[23]}}, signed_imm_24};
  assign ctrl_in   = {mem_r_en, mem_w_en, wb_en, dest};
  assign is_mul    = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_MLA);
  assign mul_acc   = (exe_cmd == CMD_MLA) ? op_c : '0;
  assign in_ready  = !rst && !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  iter_multiplier #(
    .DATA_W  (DATA_W),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .abort   (flush),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_m),
    .acc     (mul_acc),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    br_d        = br_q;
    store_d     = store_q;
    status_d    = status_q;
    ctrl_d      = ctrl_q;
    p_br_d      = p_br_q;
    p_store_d   = p_store_q;
    p_sr_d      = p_sr_q;
    p_ctrl_d    = p_ctrl_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            state_d   = MUL;
            p_br_d    = br_in;
            p_store_d = op_m;
            p_sr_d    = sr;
            p_ctrl_d  = ctrl_in;
          end else if (accept) begin
            out_valid_d = 1'b1;
            result_d    = alu_out[DATA_W-1:0];
            status_d    = alu_out[DATA_W+3:DATA_W];
            br_d        = br_in;
            store_d     = op_m;
            ctrl_d      = ctrl_in;
          end
        end
        MUL: if (mul_done) state_d = DONE;
        DONE: begin
          if (!out_valid_q || out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            result_d    = mul_prod;
            status_d    = {mul_prod[DATA_W-1], mul_prod == '0, p_sr_q[FLAG_C], p_sr_q[FLAG_V]};
            br_d        = p_br_q;
            store_d     = p_store_q;
            ctrl_d      = p_ctrl_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= '0;
      store_q     <= '0;
      status_q    <= '0;
      ctrl_q      <= '0;
      p_br_q      <= '0;
      p_store_q   <= '0;
      p_sr_q      <= '0;
      p_ctrl_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      br_q        <= br_d;
      store_q     <= store_d;
      status_q    <= status_d;
      ctrl_q      <= ctrl_d;
      p_br_q      <= p_br_d;
      p_store_q   <= p_store_d;
      p_sr_q      <= p_sr_d;
      p_ctrl_q    <= p_ctrl_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign alu_result     = result_q;
  assign br_addr        = br_q;
  assign out_store_data = store_q;
  assign status         = status_q;
  assign out_mem_r_en   = ctrl_q.mem_r_en;
  assign out_mem_w_en   = ctrl_q.mem_w_en;
  assign out_wb_en      = ctrl_q.wb_en;
  assign out_dest       = ctrl_q.dest;
  assign busy           = (state_q == MUL);

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed + randomized bench for exec_stage_mc at default parameters,
// checked against an arithmetic reference model.
module tb_exec_stage_mc;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] pc_in, val_rn, val_rm, val_ra, alu_result, br_addr, out_store_data;
  logic [3:0]  exe_cmd, dest, sr, status, out_dest;
  logic        mem_r_en, mem_w_en, wb_en, imm, out_mem_r_en, out_mem_w_en, out_wb_en;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [1:0]  src1_sel, src2_sel, src3_sel;
  logic [63:0] fwd_values;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] rn, rm, ra, f0, f1, pc;
    logic [1:0]  s1, s2, s3;
    logic        imm, mr, mw, wb;
    logic [11:0] so;
    logic [23:0] simm;
    logic [3:0]  sr, dest;
  } op_t;

  exec_stage_mc dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en(wb_en), .dest(dest), .val_rn(val_rn), .val_rm(val_rm), .val_ra(val_ra),
    .imm(imm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .sr(sr),
    .src1_sel(src1_sel), .src2_sel(src2_sel), .src3_sel(src3_sel),
    .fwd_values(fwd_values), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .br_addr(br_addr), .out_store_data(out_store_data),
    .status(status), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .out_wb_en(out_wb_en), .out_dest(out_dest), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [106:0] obs_vec();
    return {alu_result, status, br_addr, out_store_data,
            out_mem_r_en, out_mem_w_en, out_wb_en, out_dest};
  endfunction

  function automatic logic [31:0] sel_val(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] f0, input logic [31:0] f1);
    if (s == 2'd1) return f0;
    if (s == 2'd2) return f1;
    return r;
  endfunction

  // Expected output register contents for an accepted op.
  function automatic logic [106:0] model(input op_t o);
    logic [31:0] a, m, c, v2, r, br;
    logic [63:0] dbl;
    logic [3:0]  f;
    longint      ua, ub, sa, sb, sum, ss, cin;
    int          n;
    a = sel_val(o.s1, o.rn, o.f0, o.f1);
    m = sel_val(o.s2, o.rm, o.f0, o.f1);
    c = sel_val(o.s3, o.ra, o.f0, o.f1);
    if (o.imm) begin
      n   = 2 * int'(o.so[11:8]);
      dbl = {24'h0, o.so[7:0], 24'h0, o.so[7:0]};
      v2  = dbl[n +: 32];
    end else if (o.mr || o.mw) begin
      v2 = {20'h0, o.so};
    end else begin
      n = int'(o.so[11:7]);
      dbl = {m, m};
      case (o.so[6:5])
        2'd0: v2 = m << n;
        2'd1: v2 = m >> n;
        2'd2: v2 = $signed(m) >>> n;
        default: v2 = dbl[n +: 32];
      endcase
    end
    f   = o.sr;
    r   = 32'h0;
    cin = o.sr[1] ? 64'sd1 : 64'sd0;
    ua  = longint'(a);
    ub  = longint'(v2);
    sa  = longint'($signed(a));
    sb  = longint'($signed(v2));
    sum = 0;
    ss  = 0;
    case (o.cmd)
      4'd2: begin sum = ua + ub;           ss = sa + sb;           end
      4'd3: begin sum = ua + ub + cin;     ss = sa + sb + cin;     end
      4'd4: begin sum = ua - ub;           ss = sa - sb;           end
      4'd5: begin sum = ua - ub - (1-cin); ss = sa - sb - (1-cin); end
      default: ;
    endcase
    case (o.cmd)
      4'd1: r = v2;
      4'd9: r = ~v2;
      4'd6: r = a & v2;
      4'd7: r = a | v2;
      4'd8: r = a ^ v2;
      4'd10: r = a * m;
      4'd11: r = a * m + c;
      4'd2, 4'd3, 4'd4, 4'd5: begin
        r    = 32'(sum);
        f[1] = (o.cmd <= 4'd3) ? (sum > 64'sh0FFFFFFFF) : (sum >= 0);
        f[0] = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
      end
      default: ;
    endcase
    if (o.cmd >= 4'd1 && o.cmd <= 4'd11) begin
      f[3] = r[31];
      f[2] = (r == 32'h0);
    end
    br = o.pc + 32'(int'($signed(o.simm)));
    return {r, f, br, m, o.mr, o.mw, o.wb, o.dest};
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic op_t rand_op(input bit mul);
    op_t o;
    int  k;
    k      = $urandom_range(0, 13);
    o.cmd  = mul ? 4'(10 + $urandom_range(0, 1)) : 4'((k < 10) ? k : k + 2);
    o.rn   = rval();  o.rm = rval();  o.ra = rval();
    o.f0   = rval();  o.f1 = rval();  o.pc = $urandom();
    o.s1   = 2'($urandom_range(0, 3));
    o.s2   = 2'($urandom_range(0, 3));
    o.s3   = 2'($urandom_range(0, 3));
    o.imm  = ($urandom_range(0, 3) == 0);
    k      = $urandom_range(0, 3);
    o.mr   = (k == 1);
    o.mw   = (k == 2);
    o.wb   = 1'($urandom_range(0, 1));
    o.so   = 12'($urandom());
    o.simm = 24'($urandom());
    o.sr   = 4'($urandom());
    o.dest = 4'($urandom());
    return o;
  endfunction

  function automatic op_t zero_op();
    op_t o;
    o = rand_op(1'b0);
    o.cmd = 4'd0; o.rn = 0; o.rm = 0; o.ra = 0; o.f0 = 0; o.f1 = 0; o.pc = 0;
    o.s1 = 0; o.s2 = 0; o.s3 = 0; o.imm = 0; o.mr = 0; o.mw = 0; o.wb = 0;
    o.so = 0; o.simm = 0; o.sr = 0; o.dest = 0;
    return o;
  endfunction

  task automatic drive(input op_t o);
    exe_cmd = o.cmd; val_rn = o.rn; val_rm = o.rm; val_ra = o.ra;
    fwd_values = {o.f1, o.f0}; pc_in = o.pc;
    src1_sel = o.s1; src2_sel = o.s2; src3_sel = o.s3;
    imm = o.imm; mem_r_en = o.mr; mem_w_en = o.mw; wb_en = o.wb;
    shift_operand = o.so; signed_imm_24 = o.simm; sr = o.sr; dest = o.dest;
  endtask

  // drive, confirm acceptance is offered, take one edge
  task automatic accept_op(input op_t o, input string tag);
    drive(o);
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic issue_chk(input op_t o, input string tag);
    accept_op(o, tag);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_out"}, obs_vec(), model(o));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int  i;
    bit  got;
    got = 1'b0;
    for (i = 0; i < budget && !got; i++) begin
      val_rn = $urandom(); val_rm = $urandom(); val_ra = $urandom();
      fwd_values = {$urandom(), $urandom()};
      step();
      got = out_valid;
    end
    chk({tag, "_arrive"}, got, 1'b1);
  endtask

  initial begin
    op_t o, x, y;
    bit  seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(zero_op());
    step();
    step();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_state", {out_valid, busy, obs_vec()}, 109'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    o = zero_op(); o.cmd = 4'd2; o.f0 = 32'd5; o.rn = 32'd99; o.rm = 32'd7;
    o.s1 = 2'd1; o.pc = 32'h1000; o.simm = 24'hFFFFFE; o.wb = 1'b1; o.dest = 4'd3;
    issue_chk(o, "add_fwd");
    chk("add_fwd_res", {alu_result, status}, {32'd12, 4'b0000});
    chk("add_fwd_br", br_addr, 32'h0FFE);

    o = zero_op(); o.cmd = 4'd4; o.rn = 32'd3; o.rm = 32'd5;
    issue_chk(o, "sub");
    chk("sub_res", {alu_result, status}, {32'hFFFFFFFE, 4'b1000});

    o = zero_op(); o.cmd = 4'd3; o.rn = 32'hFFFFFFFF; o.sr = 4'b0010;
    issue_chk(o, "adc");
    chk("adc_res", {alu_result, status}, {32'h0, 4'b0110});

    o = zero_op(); o.cmd = 4'd1; o.imm = 1'b1; o.so = 12'h4FF; o.sr = 4'b0011;
    issue_chk(o, "mov_imm");
    chk("mov_imm_res", {alu_result, status}, {32'hFF000000, 4'b1011});

    o = zero_op(); o.cmd = 4'd2; o.mw = 1'b1; o.so = 12'hABC; o.rm = 32'h12345678;
    issue_chk(o, "str");
    chk("str_res", {alu_result, out_store_data, out_mem_w_en}, {32'hABC, 32'h12345678, 1'b1});

    for (int i = 0; i < 40; i++) issue_chk(rand_op(1'b0), "rand_alu");
    step();
    chk("drain_valid", out_valid, 1'b0);

    o = zero_op(); o.cmd = 4'd11; o.rn = 32'h10000; o.rm = 32'h10000; o.ra = 32'd3;
    o.sr = 4'b0011; o.dest = 4'd9; o.wb = 1'b1;
    accept_op(o, "mla");
    drive(rand_op(1'b0));
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ({busy, in_ready, out_valid} !== 3'b100) seen = 1'b1;
      step();
    end
    chk("mla_busy16", seen, 1'b0);
    chk("mla_done_gap", {busy, out_valid}, 2'b00);
    step();
    chk("mla_valid", out_valid, 1'b1);
    chk("mla_res", {alu_result, status}, {32'd3, 4'b0011});
    chk("mla_out", obs_vec(), model(o));

    out_ready = 1'b0;
    x = rand_op(1'b0);
    drive(x);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_hold", {out_valid, obs_vec()}, {1'b1, model(o)});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("b2b_out", {out_valid, obs_vec()}, {1'b1, model(x)});
    step();
    chk("b2b_drain", out_valid, 1'b0);

    for (int j = 0; j < 6; j++) begin
      o = rand_op(1'b1);
      accept_op(o, "rand_mul");
      wait_valid("rand_mul", 40);
      chk("rand_mul_out", obs_vec(), model(o));
      step();
    end

    accept_op(rand_op(1'b1), "flush_mul");
    for (int i = 0; i < 7; i++) step();
    flush = 1'b1;
    drive(rand_op(1'b0));
    in_valid = 1'b1;
    #1;
    chk("flush_blocks_accept", in_ready, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_idle", {busy, out_valid, in_ready}, 3'b001);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", seen, 1'b0);

    out_ready = 1'b0;
    o = rand_op(1'b0);
    issue_chk(o, "flush_idle_op");
    flush = 1'b1;
    y = rand_op(1'b0);
    drive(y);
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush_keeps_data", {out_valid, obs_vec()}, {1'b0, model(o)});

    accept_op(rand_op(1'b1), "rst_mul");
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_mul", {busy, out_valid, obs_vec()}, 109'h0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid || busy) seen = 1'b1;
    end
    chk("rst_no_result", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
